// File: rtl/assignment_trail.sv
// rtl/assignment_trail.sv - assignment trail stack with lit_assigned/lit_value vectors and chronological backtrack
module assignment_trail #(
    parameter int WIDTH = 8,
    parameter int N = 256,
    localparam int CW = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [WIDTH-1:0] dec_lit,
    input  logic             dec_val,
    input  logic             imp_valid,
    input  logic [WIDTH-1:0] imp_lit,
    input  logic             imp_val,
    input  logic             bt_req,
    output logic [N-1:0]     lit_assigned,
    output logic [N-1:0]     lit_value,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    trail_count,
    output logic             busy,
    output logic             push_ack,
    output logic             push_rej,
    output logic             bt_done,
    output logic             unsat
);

    typedef enum logic [1:0] {IDLE, POP, FLIP} state_t;

    // Entry layout: {lit, val, is_dec}
    logic [WIDTH+1:0] trail_mem [N];

    state_t           state_q, state_d;
    logic [N-1:0]     lit_assigned_q, lit_assigned_d;
    logic [N-1:0]     lit_value_q, lit_value_d;
    logic [CW-1:0]    level_q, level_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             push_ack_q, push_ack_d;
    logic             push_rej_q, push_rej_d;
    logic             bt_done_q, bt_done_d;
    logic             unsat_q, unsat_d;
    logic [WIDTH-1:0] flip_lit_q, flip_lit_d;
    logic             flip_val_q, flip_val_d;

    logic             trail_we;
    logic [WIDTH+1:0] trail_wdata;
    logic [WIDTH-1:0] wr_idx;
    logic [WIDTH-1:0] top_idx;
    logic [WIDTH+1:0] top_entry;
    logic [WIDTH-1:0] top_lit;
    logic [WIDTH-1:0] push_lit;
    logic             push_val;
    logic             push_dec;

    assign wr_idx    = WIDTH'(count_q);
    assign top_idx   = WIDTH'(count_q - CW'(1));
    assign top_entry = trail_mem[top_idx];
    assign top_lit   = top_entry[WIDTH+1:2];

    always_comb begin
        state_d        = state_q;
        lit_assigned_d = lit_assigned_q;
        lit_value_d    = lit_value_q;
        level_d        = level_q;
        count_d        = count_q;
        busy_d         = busy_q;
        push_ack_d     = 1'b0;
        push_rej_d     = 1'b0;
        bt_done_d      = 1'b0;
        unsat_d        = 1'b0;
        flip_lit_d     = flip_lit_q;
        flip_val_d     = flip_val_q;
        trail_we       = 1'b0;
        trail_wdata    = '0;
        // Implications outrank decisions; the loser of a same-cycle pair is simply dropped
        push_lit = imp_valid ? imp_lit : dec_lit;
        push_val = imp_valid ? imp_val : dec_val;
        push_dec = !imp_valid;

        case (state_q)
            IDLE: begin
                if (bt_req) begin
                    if (level_q == '0) begin
                        unsat_d = 1'b1;
                    end else begin
                        state_d = POP;
                        busy_d  = 1'b1;
                    end
                end else if (imp_valid || dec_valid) begin
                    if (push_lit != '0 && !lit_assigned_q[push_lit] && count_q < CW'(N)) begin
                        trail_we                = 1'b1;
                        trail_wdata             = {push_lit, push_val, push_dec};
                        count_d                 = count_q + CW'(1);
                        lit_assigned_d[push_lit] = 1'b1;
                        lit_value_d[push_lit]    = push_val;
                        if (push_dec) begin
                            level_d = level_q + CW'(1);
                        end
                        push_ack_d = 1'b1;
                    end else begin
                        push_rej_d = 1'b1;
                    end
                end
            end
            POP: begin
                count_d                 = count_q - CW'(1);
                lit_assigned_d[top_lit] = 1'b0;
                lit_value_d[top_lit]    = 1'b0;
                if (top_entry[0]) begin
                    flip_lit_d = top_lit;
                    flip_val_d = top_entry[1];
                    level_d    = level_q - CW'(1);
                    state_d    = FLIP;
                end
            end
            FLIP: begin
                // Re-pushed as an implication so it is never flipped a second time
                trail_we                   = 1'b1;
                trail_wdata                = {flip_lit_q, ~flip_val_q, 1'b0};
                count_d                    = count_q + CW'(1);
                lit_assigned_d[flip_lit_q] = 1'b1;
                lit_value_d[flip_lit_q]    = ~flip_val_q;
                bt_done_d                  = 1'b1;
                busy_d                     = 1'b0;
                state_d                    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lit_assigned_q <= '0;
            lit_value_q    <= '0;
            level_q        <= '0;
            count_q        <= '0;
            busy_q         <= 1'b0;
            push_ack_q     <= 1'b0;
            push_rej_q     <= 1'b0;
            bt_done_q      <= 1'b0;
            unsat_q        <= 1'b0;
            flip_lit_q     <= '0;
            flip_val_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lit_assigned_q <= lit_assigned_d;
            lit_value_q    <= lit_value_d;
            level_q        <= level_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            push_ack_q     <= push_ack_d;
            push_rej_q     <= push_rej_d;
            bt_done_q      <= bt_done_d;
            unsat_q        <= unsat_d;
            flip_lit_q     <= flip_lit_d;
            flip_val_q     <= flip_val_d;
        end
    end

    // Trail contents are don't-care after reset, so the stack memory carries no reset
    always_ff @(posedge clk) begin
        if (trail_we) begin
            trail_mem[wr_idx] <= trail_wdata;
        end
    end

    assign lit_assigned = lit_assigned_q;
    assign lit_value    = lit_value_q;
    assign level        = level_q;
    assign trail_count  = count_q;
    assign busy         = busy_q;
    assign push_ack     = push_ack_q;
    assign push_rej     = push_rej_q;
    assign bt_done      = bt_done_q;
    assign unsat        = unsat_q;

endmodule
